text_overlay: RTL and testbench

- Character-cell text renderer that drives the glyph ROM from the VGA pixel stream.
- Holds a small character buffer of 6-bit glyph codes, written by game logic for labels and scores.
- Maps each incoming pixel coordinate to a cell, glyph row and glyph column, and returns the ROM's pixel aligned with the delayed sync/blank signals.
- Sits between the VGA sync generator and the colour mux.

---
 rtl/text_overlay.sv | 191 +++++++++++++++++++
 tb/tb_text_overlay.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_overlay.sv
// text_overlay: character-cell text renderer between the VGA sync generator
// and the colour mux. Holds a buffer of 6-bit glyph codes, maps each pixel
// coordinate to a cell and a glyph row/column for the glyph ROM, and returns
// the ROM pixel aligned with sync/blank delayed by three cycles.
//
// Ports:
//   clk, reset                 pixel clock, asynchronous active-high reset
//   pixel_x, pixel_y           current pixel coordinate from the sync generator
//   video_on, hsync_in, vsync_in  active-video flag and syncs
//   wr_en, wr_addr, wr_data    buffer write port (addr = row*TEXT_COLS + col)
//   char_index, glyph_row, glyph_column  glyph ROM address
//   glyph_pixel                combinational glyph ROM result
//   text_pixel, text_valid     foreground pixel and in-window flag
//   video_on_out, hsync_out, vsync_out  inputs delayed three cycles
//   clear_busy                 high while the post-reset buffer clear runs
module text_overlay #(
    parameter int unsigned TEXT_COLS  = 16,
    parameter int unsigned TEXT_ROWS  = 2,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned ORIGIN_X   = 256,
    parameter int unsigned ORIGIN_Y   = 32,
    parameter int unsigned SCALE_LOG2 = 1,
    parameter int unsigned BLANK_CODE = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              video_on,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [5:0]        wr_data,
    output logic [5:0]        char_index,
    output logic [2:0]        glyph_row,
    output logic [2:0]        glyph_column,
    input  logic              glyph_pixel,
    output logic              text_pixel,
    output logic              text_valid,
    output logic              video_on_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              clear_busy
);

    localparam int unsigned CELLS      = TEXT_COLS * TEXT_ROWS;
    localparam int unsigned CELL_SHIFT = 3 + SCALE_LOG2;
    localparam int unsigned WIN_W      = TEXT_COLS << CELL_SHIFT;
    localparam int unsigned WIN_H      = TEXT_ROWS << CELL_SHIFT;
    localparam int unsigned DEPTH      = 1 << ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clear_cnt;

    logic [5:0] char_buf [DEPTH];

    // S1 registers
    logic              s1_in_win;
    logic [ADDR_W-1:0] s1_cell_col;
    logic [ADDR_W-1:0] s1_cell_row;
    logic [2:0]        s1_gcol;
    logic [2:0]        s1_grow;
    logic              s1_video;
    logic              s1_hsync;
    logic              s1_vsync;

    // S2 registers (glyph row/column and char_index are the S2 outputs)
    logic              s2_in_win;
    logic              s2_video;
    logic              s2_hsync;
    logic              s2_vsync;

    // Offsets are 11 bits so coordinates left of/above the origin fail the
    // explicit >= compare instead of wrapping into the window.
    logic [10:0]       dx_c;
    logic [10:0]       dy_c;
    logic              in_win_c;
    logic [ADDR_W-1:0] rd_addr_c;

    assign dx_c = 11'(pixel_x) - 11'(ORIGIN_X);
    assign dy_c = 11'(pixel_y) - 11'(ORIGIN_Y);

    assign in_win_c = (pixel_x >= 10'(ORIGIN_X)) && (dx_c < 11'(WIN_W)) &&
                      (pixel_y >= 10'(ORIGIN_Y)) && (dy_c < 11'(WIN_H));

    assign rd_addr_c = ADDR_W'(s1_cell_row * ADDR_W'(TEXT_COLS) + s1_cell_col);

    // Buffer write port: the clear sweep owns it until RUN; user writes
    // beyond the last cell are dropped rather than wrapped.
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_waddr_c;
    logic [5:0]        mem_wdata_c;

    always_comb begin
        mem_we_c    = 1'b0;
        mem_waddr_c = wr_addr;
        mem_wdata_c = wr_data;
        if (state == CLEAR) begin
            mem_we_c    = 1'b1;
            mem_waddr_c = clear_cnt;
            mem_wdata_c = 6'(BLANK_CODE);
        end else if (wr_en && (32'(wr_addr) < CELLS)) begin
            mem_we_c = 1'b1;
        end
    end

    // Character buffer storage; a same-edge read sees the old code.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            char_buf[mem_waddr_c] <= mem_wdata_c;
        end
    end

    // Clear FSM and the three-stage pixel pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= CLEAR;
            clear_cnt    <= '0;
            clear_busy   <= 1'b1;
            s1_in_win    <= 1'b0;
            s1_cell_col  <= '0;
            s1_cell_row  <= '0;
            s1_gcol      <= '0;
            s1_grow      <= '0;
            s1_video     <= 1'b0;
            s1_hsync     <= 1'b0;
            s1_vsync     <= 1'b0;
            s2_in_win    <= 1'b0;
            s2_video     <= 1'b0;
            s2_hsync     <= 1'b0;
            s2_vsync     <= 1'b0;
            char_index   <= 6'(BLANK_CODE);
            glyph_row    <= '0;
            glyph_column <= '0;
            text_pixel   <= 1'b0;
            text_valid   <= 1'b0;
            video_on_out <= 1'b0;
            hsync_out    <= 1'b0;
            vsync_out    <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clear_cnt == ADDR_W'(CELLS - 1)) begin
                        state      <= RUN;
                        clear_busy <= 1'b0;
                    end
                    clear_cnt <= clear_cnt + ADDR_W'(1);
                end
                RUN: begin
                    clear_busy <= 1'b0;
                end
                default: begin
                    state <= CLEAR;
                end
            endcase

            // S1: coordinate to cell / glyph position
            s1_in_win   <= in_win_c;
            s1_cell_col <= ADDR_W'(dx_c >> CELL_SHIFT);
            s1_cell_row <= ADDR_W'(dy_c >> CELL_SHIFT);
            s1_gcol     <= 3'(dx_c >> SCALE_LOG2);
            s1_grow     <= 3'(dy_c >> SCALE_LOG2);
            s1_video    <= video_on;
            s1_hsync    <= hsync_in;
            s1_vsync    <= vsync_in;

            // S2: buffer read; outside the window the ROM sees the blank glyph
            char_index   <= s1_in_win ? char_buf[rd_addr_c] : 6'(BLANK_CODE);
            glyph_row    <= s1_grow;
            glyph_column <= s1_gcol;
            s2_in_win    <= s1_in_win;
            s2_video     <= s1_video;
            s2_hsync     <= s1_hsync;
            s2_vsync     <= s1_vsync;

            // S3: gate the ROM pixel
            text_pixel   <= glyph_pixel & s2_in_win & s2_video & (state == RUN);
            text_valid   <= s2_in_win;
            video_on_out <= s2_video;
            hsync_out    <= s2_hsync;
            vsync_out    <= s2_vsync;
        end
    end

endmodule

// File: tb/tb_text_overlay.sv
// Directed bench for text_overlay: reset/clear timing, glyph addressing,
// window edges, read-before-write, dropped writes and sync delay.
module tb_text_overlay;

    localparam int unsigned AW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic [9:0]    pixel_x;
    logic [9:0]    pixel_y;
    logic          video_on;
    logic          hsync_in;
    logic          vsync_in;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [5:0]    wr_data;
    logic [5:0]    char_index;
    logic [2:0]    glyph_row;
    logic [2:0]    glyph_column;
    logic          glyph_pixel;
    logic          text_pixel;
    logic          text_valid;
    logic          video_on_out;
    logic          hsync_out;
    logic          vsync_out;
    logic          clear_busy;

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_buf [32];

    always #5 clk = ~clk;

    // Wider address port so an address past the 32 cells can be driven.
    text_overlay #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .char_index(char_index), .glyph_row(glyph_row), .glyph_column(glyph_column),
        .glyph_pixel(glyph_pixel), .text_pixel(text_pixel), .text_valid(text_valid),
        .video_on_out(video_on_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .clear_busy(clear_busy)
    );

    // Glyph ROM stand-in: code 31 is all black, others a checker pattern.
    function automatic logic rom(input logic [5:0] c, input logic [2:0] r, input logic [2:0] k);
        logic [2:0] t;
        t = (r ^ k) + c[2:0];
        return (c != 6'd31) && t[0];
    endfunction

    assign glyph_pixel = rom(char_index, glyph_row, glyph_column);

    task automatic do_write(input int a, input int d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = 6'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic probe(input int x, input int y, input logic vid,
                         output logic [5:0] ci, output logic [2:0] gr, output logic [2:0] gc,
                         output logic tp, output logic tv);
        @(negedge clk);
        pixel_x = 10'(x); pixel_y = 10'(y); video_on = vid;
        @(posedge clk);
        @(posedge clk); #1;
        ci = char_index; gr = glyph_row; gc = glyph_column;
        @(posedge clk); #1;
        tp = text_pixel; tv = text_valid;
    endtask

    task automatic count_clear(input string name);
        int n;
        n = 0;
        while (clear_busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL %s clear_busy cycles got %0d want 32", name, n);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        hsync_in = 1'b1; vsync_in = 1'b1; video_on = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({char_index, glyph_row, glyph_column} !== {6'd31, 3'd0, 3'd0}) begin
            errors++;
            $display("FAIL reset_rom_addr got %h/%h/%h want 1f/0/0", char_index, glyph_row, glyph_column);
        end
        checks++;
        if ({text_pixel, text_valid, video_on_out, hsync_out, vsync_out, clear_busy} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_outputs got %b want 000001",
                     {text_pixel, text_valid, video_on_out, hsync_out, vsync_out, clear_busy});
        end
        hsync_in = 1'b0; vsync_in = 1'b0; video_on = 1'b0;
        reset = 1'b0;
        count_clear("reset_clear");
    endtask

    // Reset re-asserted 10 cycles into a clear; a write issued meanwhile is lost.
    task automatic test_clear_restart;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        wr_en = 1'b1; wr_addr = AW'(5); wr_data = 6'd7;
        repeat (3) @(negedge clk);
        wr_en = 1'b0;
        repeat (7) @(negedge clk);
        checks++;
        if (clear_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_clear_busy got %b want 1", clear_busy);
        end
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        count_clear("restart_clear");
    endtask

    task automatic test_readback(input string name);
        logic [5:0] ci; logic [2:0] gr, gc; logic tp, tv;
        for (int a = 0; a < 32; a++) begin
            probe(256 + (a % 16) * 16, 32 + (a / 16) * 16, 1'b1, ci, gr, gc, tp, tv);
            checks++;
            if (ci !== exp_buf[a] || tp !== rom(exp_buf[a], 3'd0, 3'd0)) begin
                errors++;
                $display("FAIL %s cell %0d got code %0d pix %b want code %0d pix %b",
                         name, a, ci, tp, exp_buf[a], rom(exp_buf[a], 3'd0, 3'd0));
            end
        end
    endtask

    task automatic test_glyph_scan;
        logic [5:0] ci; logic [2:0] gr, gc; logic tp, tv;
        logic [2:0] egr, egc;
        do_write(0, 0);
        exp_buf[0] = 6'd0;
        for (int y = 32; y < 48; y++) begin
            for (int x = 256; x < 272; x++) begin
                probe(x, y, 1'b1, ci, gr, gc, tp, tv);
                egc = 3'((x - 256) / 2);
                egr = 3'((y - 32) / 2);
                checks++;
                if (ci !== 6'd0 || gr !== egr || gc !== egc || tp !== rom(6'd0, egr, egc) || tv !== 1'b1) begin
                    errors++;
                    $display("FAIL scan x=%0d y=%0d got ci=%0d r=%0d c=%0d p=%b v=%b want 0 %0d %0d %b 1",
                             x, y, ci, gr, gc, tp, tv, egr, egc, rom(6'd0, egr, egc));
                end
            end
        end
    endtask

    task automatic test_window_edges;
        logic [5:0] ci; logic [2:0] gr, gc; logic tp, tv;
        int xs [4] = '{255, 512, 300, 300};
        int ys [4] = '{40, 40, 31, 64};
        for (int i = 0; i < 4; i++) begin
            probe(xs[i], ys[i], 1'b1, ci, gr, gc, tp, tv);
            checks++;
            if (tv !== 1'b0 || ci !== 6'd31 || tp !== 1'b0) begin
                errors++;
                $display("FAIL outside x=%0d y=%0d got v=%b ci=%0d p=%b want 0 31 0",
                         xs[i], ys[i], tv, ci, tp);
            end
        end
        do_write(31, 9);
        exp_buf[31] = 6'd9;
        probe(511, 63, 1'b1, ci, gr, gc, tp, tv);
        checks++;
        if (tv !== 1'b1 || ci !== 6'd9 || gr !== 3'd7 || gc !== 3'd7 || tp !== 1'b1) begin
            errors++;
            $display("FAIL last_pixel got v=%b ci=%0d r=%0d c=%0d p=%b want 1 9 7 7 1", tv, ci, gr, gc, tp);
        end
        probe(256, 32, 1'b1, ci, gr, gc, tp, tv);
        checks++;
        if (tv !== 1'b1 || ci !== 6'd0 || gr !== 3'd0 || gc !== 3'd0 || tp !== 1'b0) begin
            errors++;
            $display("FAIL origin got v=%b ci=%0d r=%0d c=%0d p=%b want 1 0 0 0 0", tv, ci, gr, gc, tp);
        end
        // lit ROM pixel with video off stays dark
        probe(258, 32, 1'b0, ci, gr, gc, tp, tv);
        checks++;
        if (tv !== 1'b1 || gc !== 3'd1 || tp !== 1'b0) begin
            errors++;
            $display("FAIL video_off got v=%b c=%0d p=%b want 1 1 0", tv, gc, tp);
        end
    endtask

    task automatic test_read_before_write;
        @(negedge clk);
        pixel_x = 10'd272; pixel_y = 10'd48; video_on = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = AW'(17); wr_data = 6'd13;
        @(posedge clk); #1;
        checks++;
        if (char_index !== 6'd31) begin
            errors++;
            $display("FAIL raw_old got %0d want 31", char_index);
        end
        @(negedge clk);
        wr_en = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (char_index !== 6'd13) begin
            errors++;
            $display("FAIL raw_new got %0d want 13", char_index);
        end
        exp_buf[17] = 6'd13;
    endtask

    task automatic test_oob_write;
        do_write(40, 3);
        do_write(63, 4);
        test_readback("oob_readback");
    endtask

    task automatic test_sync_delay;
        logic [2:0] hist [24];
        pixel_x = 10'd0; pixel_y = 10'd0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                checks++;
                if ({hsync_out, vsync_out, video_on_out} !== hist[i-3]) begin
                    errors++;
                    $display("FAIL sync_delay step %0d got %b want %b",
                             i, {hsync_out, vsync_out, video_on_out}, hist[i-3]);
                end
            end
            hist[i] = {1'(i & 1), 1'((i >> 2) & 1), 1'((i % 3) == 0)};
            {hsync_in, vsync_in, video_on} = hist[i];
        end
    endtask

    initial begin
        reset = 1'b1;
        pixel_x = '0; pixel_y = '0; video_on = 1'b0;
        hsync_in = 1'b0; vsync_in = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        for (int a = 0; a < 32; a++) exp_buf[a] = 6'd31;
        test_reset();
        test_clear_restart();
        test_readback("clear_readback");
        test_glyph_scan();
        test_window_edges();
        test_read_before_write();
        test_oob_write();
        test_sync_delay();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
